// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;
  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [31:0] byte_rev32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Reserved size, misalignment for the size, or beyond the end of memory.
  function automatic logic is_bad_access(input logic [31:0] addr, input logic [1:0] size,
                                         input int unsigned mem_size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || ({2'b00, addr} >= (34'(mem_size) << 2));
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane merge for sub-word stores and lane extraction for loads.
module dmem_lane_merge
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [4:0] w_bsh;
  logic [4:0] w_hsh;

  assign w_bsh = {i_off, 3'b000};
  assign w_hsh = {i_off[1], 4'b0000};

  always_comb begin
    o_merged = i_wdata;
    o_rdata  = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_merged = (i_word & ~(32'h0000_00FF << w_bsh)) | ({24'b0, i_wdata[7:0]} << w_bsh);
        o_rdata  = (i_word >> w_bsh) & 32'h0000_00FF;
      end
      SZ_HALF: begin
        o_merged = (i_word & ~(32'h0000_FFFF << w_hsh)) | ({16'b0, i_wdata[15:0]} << w_hsh);
        o_rdata  = (i_word >> w_hsh) & 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port access controller for the single-ported dmem;
// sub-word stores are done as read-modify-write of the whole word.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [1:0][1:0]  req_size,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             mem_we,
  output logic             mem_rde,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  state_t      r_state;
  req_t        r_req;
  logic        r_prio;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_mem_we;
  logic        r_mem_rde;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;

  logic        w_grant;
  logic        w_hs;
  logic        w_bad;
  req_t        w_new;
  logic [31:0] w_merged;
  logic [31:0] w_rdata;

  // Contested grant follows the pointer; a lone requester always wins.
  always_comb begin
    w_grant   = (req_valid == 2'b11) ? r_prio : req_valid[1];
    req_ready = 2'b00;
    if (r_state == IDLE && !reset && req_valid != 2'b00) req_ready[w_grant] = 1'b1;
    w_hs  = |(req_valid & req_ready);
    w_new = '{port: w_grant, we: req_we[w_grant], size: req_size[w_grant],
              addr: req_addr[w_grant], wdata: req_wdata[w_grant]};
    w_bad = is_bad_access(req_addr[w_grant], req_size[w_grant], MEM_SIZE);
  end

  dmem_lane_merge u_merge (
    .i_word   (byte_rev32(mem_rd)),
    .i_off    (r_req.addr[1:0]),
    .i_size   (r_req.size),
    .i_wdata  (r_req.wdata),
    .o_merged (w_merged),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_prio      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rde   <= 1'b0;
      r_mem_a     <= '0;
      r_mem_wd    <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rde   <= 1'b0;
      r_mem_a     <= '0;
      r_mem_wd    <= '0;
      case (r_state)
        IDLE: if (w_hs) begin
          r_req  <= w_new;
          r_prio <= ~w_grant;
          if (w_bad) begin
            r_rsp_valid[w_grant] <= 1'b1;
            r_rsp_err            <= 1'b1;
          end else if (w_new.we && w_new.size == 2'(SZ_WORD)) begin
            r_state  <= WR;
            r_mem_we <= 1'b1;
            r_mem_a  <= {w_new.addr[31:2], 2'b00};
            r_mem_wd <= w_new.wdata;
          end else begin
            r_state   <= RD;
            r_mem_rde <= 1'b1;
            r_mem_a   <= {w_new.addr[31:2], 2'b00};
          end
        end
        RD: r_state <= CAP;
        CAP: if (r_req.we) begin
          r_state  <= WR;
          r_mem_we <= 1'b1;
          r_mem_a  <= {r_req.addr[31:2], 2'b00};
          r_mem_wd <= w_merged;
        end else begin
          r_state                  <= IDLE;
          r_rsp_valid[r_req.port]  <= 1'b1;
          r_rsp_rdata              <= w_rdata;
        end
        WR: begin
          r_state                 <= IDLE;
          r_rsp_valid[r_req.port] <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_we    = r_mem_we;
  assign mem_rde   = r_mem_rde;
  assign mem_a     = r_mem_a;
  assign mem_wd    = r_mem_wd;

endmodule
